// File: rtl/sha256_feeder_pkg.sv
// Shared types and widths for the SHA-256 stream feeder.
// State encoding plus word, hash and counter widths.
package sha256_feeder_pkg;

  localparam int SHA_WORD_W   = 32;
  localparam int SHA_HASH_W   = 256;
  localparam int BYTE_COUNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PACK,
    S_SEND,
    S_GAP,
    S_WAIT_DONE,
    S_REPORT
  } state_t;

endpackage

// File: rtl/sha256_byte_packer.sv
// Packs bytes big-endian into a 32-bit word, zero-filling unused lanes.
// word/full/last_seen already include the byte accepted this cycle.
module sha256_byte_packer
  import sha256_feeder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            data,
  input  logic                  last,
  output logic [SHA_WORD_W-1:0] word,
  output logic                  full,
  output logic                  last_seen
);

  logic [1:0]            idx_q;
  logic [SHA_WORD_W-1:0] word_q;
  logic                  last_q;

  always_comb begin
    word = word_q;
    if (accept) begin
      unique case (idx_q)
        2'd0: word[31:24] = data;
        2'd1: word[23:16] = data;
        2'd2: word[15:8]  = data;
        2'd3: word[7:0]   = data;
      endcase
    end
  end

  assign full      = accept && (idx_q == 2'd3);
  assign last_seen = last_q || (accept && last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      word_q <= '0;
      last_q <= 1'b0;
    end else if (clear) begin
      idx_q  <= 2'd0;
      word_q <= '0;
      last_q <= 1'b0;
    end else if (accept) begin
      idx_q  <= idx_q + 2'd1;
      word_q <= word;
      last_q <= last_q || last;
    end
  end

endmodule

// File: rtl/sha256_stream_feeder.sv
// Byte stream to sha256_processor word feeder with done wait and hash capture.
// Outputs are registered from the next state so they align with it.
module sha256_stream_feeder
  import sha256_feeder_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned DONE_TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic [7:0]              s_byte,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    sha_start,
  output logic [SHA_WORD_W-1:0]   sha_data,
  output logic                    sha_valid,
  output logic                    sha_last,
  input  logic                    sha_done,
  input  logic [SHA_HASH_W-1:0]   sha_hash,
  output logic [SHA_HASH_W-1:0]   hash,
  output logic                    hash_valid,
  output logic [BYTE_COUNT_W-1:0] byte_count,
  output logic                    busy,
  output logic                    error
);

  localparam logic [31:0] GAP_END = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TMO_END = 32'(DONE_TIMEOUT - 1);

  state_t state_q, state_d;
  logic [31:0] gap_q;
  logic [31:0] tmo_q;

  logic                  accept;
  logic                  clear;
  logic                  to_hit;
  logic [SHA_WORD_W-1:0] pk_word;
  logic                  pk_full;
  logic                  pk_last;

  assign accept = s_valid && s_ready;
  assign clear  = (state_q == S_IDLE) || (state_q == S_SEND);
  assign to_hit = (state_q == S_WAIT_DONE) && !sha_done
               && (tmo_q == TMO_END);

  sha256_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .accept    (accept),
    .data      (s_byte),
    .last      (s_last),
    .word      (pk_word),
    .full      (pk_full),
    .last_seen (pk_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (req) state_d = S_START;
      S_START:     state_d = S_PACK;
      S_PACK:      if (pk_full || (accept && s_last)) state_d = S_SEND;
      S_SEND:      state_d = sha_last ? S_WAIT_DONE : S_GAP;
      S_GAP:       if (gap_q == GAP_END) state_d = S_PACK;
      S_WAIT_DONE: begin
        if (sha_done)    state_d = S_REPORT;
        else if (to_hit) state_d = S_IDLE;
      end
      S_REPORT:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      tmo_q      <= '0;
      s_ready    <= 1'b0;
      sha_start  <= 1'b0;
      sha_data   <= '0;
      sha_valid  <= 1'b0;
      sha_last   <= 1'b0;
      hash       <= '0;
      hash_valid <= 1'b0;
      byte_count <= '0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= (state_q == S_GAP) ? gap_q + 32'd1 : '0;
      tmo_q      <= (state_q == S_WAIT_DONE) ? tmo_q + 32'd1 : '0;
      s_ready    <= (state_d == S_PACK);
      sha_start  <= (state_d == S_START);
      sha_valid  <= (state_d == S_SEND);
      sha_last   <= (state_d == S_SEND) && pk_last;
      hash_valid <= (state_d == S_REPORT);
      busy       <= (state_q != S_IDLE);
      error      <= to_hit;
      if (state_d == S_SEND) sha_data <= pk_word;
      if ((state_q == S_WAIT_DONE) && sha_done) hash <= sha_hash;
      // count restarts on a new request so the last total stays readable
      if ((state_q == S_IDLE) && req) byte_count <= '0;
      else if (accept)                byte_count <= byte_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_sha256_stream_feeder.sv
// Randomized directed bench for sha256_stream_feeder with a stub processor.
// Expected words come from a byte-queue packing model.
module tb_sha256_stream_feeder;

  localparam int GAP = 1;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_m = 1'b0, req_i = 1'b0;
  logic         req;
  logic [7:0]   s_byte = 8'h00;
  logic         s_valid = 1'b0, s_last = 1'b0;
  logic         s_ready;
  logic         sha_start;
  logic [31:0]  sha_data;
  logic         sha_valid, sha_last;
  logic         done_s = 1'b0, done_i = 1'b0;
  logic         sha_done;
  logic [255:0] sha_hash = '0;
  logic [255:0] hash;
  logic         hash_valid;
  logic [31:0]  byte_count;
  logic         busy, error;

  assign req      = req_m | req_i;
  assign sha_done = done_s | done_i;

  sha256_stream_feeder #(.GAP_CYCLES(GAP), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .sha_start(sha_start), .sha_data(sha_data), .sha_valid(sha_valid),
    .sha_last(sha_last), .sha_done(sha_done), .sha_hash(sha_hash),
    .hash(hash), .hash_valid(hash_valid), .byte_count(byte_count),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]   msg_q[$];
  logic [31:0]  words_q[$];
  bit           lasts_q[$];
  int           vcyc_q[$];
  int           start_cnt, start_cyc, hv_cnt, err_cnt, err_cyc;
  logic [255:0] hv_hash, exp_hash;
  logic [31:0]  hv_bc;
  bit           stub_en = 1'b1;
  bit           inj_en = 1'b0, inj_req_done, inj_gap_next, inj_gap_done;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sha_valid) begin
        words_q.push_back(sha_data);
        lasts_q.push_back(sha_last);
        vcyc_q.push_back(cyc);
      end
      if (sha_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (hash_valid) begin
        hv_cnt++;
        hv_hash = hash;
        hv_bc = byte_count;
      end
      if (error) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // stub processor: done three cycles after the last word, hash valid only then
  int pend = 0;
  always @(negedge clk) begin
    done_s = 1'b0;
    if (!rst_n) pend = 0;
    else if (stub_en && sha_valid && sha_last) pend = 3;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) done_s = 1'b1;
    end
    if (done_s) sha_hash = exp_hash;
    else sha_hash = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
  end

  always @(negedge clk) begin
    req_i  = 1'b0;
    done_i = 1'b0;
    if (inj_en) begin
      if (!inj_req_done && s_ready) begin
        req_i = 1'b1;
        inj_req_done = 1'b1;
      end
      if (inj_gap_next) begin
        done_i = 1'b1;
        inj_gap_next = 1'b0;
      end
      if (sha_valid && !sha_last && !inj_gap_done) begin
        inj_gap_next = 1'b1;
        inj_gap_done = 1'b1;
      end
    end
  end

  task automatic reset_chk(input string tag);
    chk({tag, "_flags"}, 256'({s_ready, sha_start, sha_valid, sha_last,
                              hash_valid, busy, error}), 256'(0));
    chk({tag, "_data"}, 256'(sha_data), 256'(0));
    chk({tag, "_hash"}, hash, 256'(0));
    chk({tag, "_bc"}, 256'(byte_count), 256'(0));
  endtask

  task automatic run_msg(input int bub, input int lim);
    int i, budget, k;
    bit acc;
    words_q.delete();
    lasts_q.delete();
    vcyc_q.delete();
    start_cnt = 0;
    hv_cnt = 0;
    err_cnt = 0;
    exp_hash = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    req_m = 1'b1;
    @(negedge clk);
    req_m = 1'b0;
    i = 0;
    budget = 0;
    while (i < lim && budget < 3000) begin
      s_byte  = msg_q[i];
      s_last  = (i == msg_q.size() - 1);
      s_valid = ($urandom_range(0, 99) >= bub);
      acc = s_valid && s_ready;
      @(negedge clk);
      budget++;
      if (acc) i++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("bytes_sent", 256'(i), 256'(lim));
    if (lim == msg_q.size()) begin
      chk("busy_active", 256'(busy), 256'(1));
      k = 0;
      while (hv_cnt == 0 && err_cnt == 0 && k < 400) begin
        @(negedge clk);
        k++;
      end
      chk("finished", 256'(hv_cnt + err_cnt > 0), 256'(1));
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic check_msg(input bit nobub);
    int n, nw, nb;
    logic [31:0] ew;
    n  = msg_q.size();
    nw = (n + 3) / 4;
    chk("word_cnt", 256'(words_q.size()), 256'(nw));
    for (int w = 0; w < nw && w < words_q.size(); w++) begin
      ew = '0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < n) ew[31 - 8 * b -: 8] = msg_q[4 * w + b];
      chk("word", 256'(words_q[w]), 256'(ew));
      chk("last", 256'(lasts_q[w]), 256'(w == nw - 1));
      nb = (n - 4 * w > 4) ? 4 : n - 4 * w;
      if (nobub && w == 0)
        chk("first_lat", 256'(vcyc_q[0] - start_cyc), 256'(1 + nb));
      else if (nobub)
        chk("period", 256'(vcyc_q[w] - vcyc_q[w - 1]), 256'(nb + 1 + GAP));
    end
    chk("start_cnt", 256'(start_cnt), 256'(1));
    chk("hv_cnt", 256'(hv_cnt), 256'(1));
    chk("hash", hv_hash, exp_hash);
    chk("byte_count", 256'(hv_bc), 256'(n));
    chk("busy_idle", 256'(busy), 256'(0));
  endtask

  initial begin
    logic [255:0] prev_hash;
    int n;
    repeat (3) @(negedge clk);
    reset_chk("reset");
    rst_n = 1'b1;

    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(0, 3);
    check_msg(1'b1);
    chk("abc_word", 256'(words_q[0]), 256'(32'h61626300));

    msg_q.delete();
    for (int i = 1; i <= 64; i++) msg_q.push_back(8'(i));
    run_msg(0, 64);
    check_msg(1'b1);
    chk("w64_first", 256'(words_q[0]), 256'(32'h01020304));
    chk("w64_last", 256'(words_q[15]), 256'(32'h3D3E3F40));

    msg_q.delete();
    repeat (56) msg_q.push_back(8'hAA);
    run_msg(40, 56);
    check_msg(1'b0);

    for (int r = 0; r < 4; r++) begin
      msg_q.delete();
      n = $urandom_range(1, 70);
      repeat (n) msg_q.push_back(8'($urandom));
      run_msg((r % 2) * 30, n);
      check_msg(r % 2 == 0);
    end

    msg_q.delete();
    repeat (12) msg_q.push_back(8'($urandom));
    inj_req_done = 1'b0;
    inj_gap_next = 1'b0;
    inj_gap_done = 1'b0;
    inj_en = 1'b1;
    run_msg(0, 12);
    inj_en = 1'b0;
    check_msg(1'b1);

    prev_hash = hv_hash;
    stub_en = 1'b0;
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(0, 3);
    stub_en = 1'b1;
    chk("tmo_err_cnt", 256'(err_cnt), 256'(1));
    chk("tmo_err_lat", 256'(err_cyc - vcyc_q[0]), 256'(TMO + 1));
    chk("tmo_hv", 256'(hv_cnt), 256'(0));
    chk("tmo_hash", hash, prev_hash);
    chk("tmo_busy", 256'(busy), 256'(0));

    msg_q.delete();
    for (int i = 1; i <= 64; i++) msg_q.push_back(8'(i));
    run_msg(0, 10);
    rst_n = 1'b0;
    #1;
    reset_chk("midrst");
    chk("midrst_words", 256'(words_q.size()), 256'(2));
    chk("midrst_nolast", 256'(lasts_q.sum() with (int'(item))), 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(0, 3);
    check_msg(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_stream_feeder.md
# sha256_stream_feeder

Drives the input side of `sha256_processor`. It accepts a byte-wide valid/ready message stream and packs the bytes big-endian into 32-bit words. It then issues the start / data_valid / last_data sequence the processor expects, waits for `done`, and returns the captured 256-bit hash with a one-cycle strobe. It sits between a byte source (DMA or UART front end) and `sha256_processor`.

## Interface
- `GAP_CYCLES`, 1: idle cycles inserted after each non-last data_valid pulse (≥1).
- `DONE_TIMEOUT`, 4096: cycles allowed in WAIT_DONE before `error` fires.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 1: pulse to begin a message; sampled only in IDLE.
- `s_byte` in 8: upstream message byte.
- `s_valid` in 1: upstream byte valid.
- `s_last` in 1: marks the final byte of the message.
- `s_ready` out 1: feeder accepts a byte when `s_valid && s_ready`.
- `sha_start` out 1: one-cycle start pulse to the processor.
- `sha_data` out 32: packed word, big-endian.
- `sha_valid` out 1: word strobe, one cycle per word.
- `sha_last` out 1: set with the final `sha_valid`.
- `sha_done` in 1: processor done (level or pulse).
- `sha_hash` in 256: processor final hash.
- `hash` out 256: captured digest.
- `hash_valid` out 1: one-cycle strobe when `hash` updates.
- `byte_count` out 32: bytes accepted for the current or last message.
- `busy` out 1: high in every state except IDLE.
- `error` out 1: one-cycle pulse on done timeout.

## Operation
- FSM states: IDLE, START, PACK, SEND, GAP, WAIT_DONE, REPORT.
- IDLE:
  - `req`=1 → START.
  - Clears the packer and `byte_count`.
  - `hash` is held.
- START: `sha_start`=1 for exactly one cycle, then → PACK.
- PACK:
  - `s_ready`=1. Each accepted byte k (0..3) goes to bits [31-8k:24-8k]; unfilled bytes are 0.
  - `byte_count` increments per accepted byte.
  - 4th byte accepted, or any byte with `s_last` → SEND.
  - Upstream bubbles (`s_valid`=0) simply stall.
- SEND:
  - `sha_valid`=1 for one cycle with the packed word.
  - `sha_last`=1 iff the word holds the `s_last` byte.
  - Last word → WAIT_DONE; otherwise → GAP.
- GAP: `sha_valid`=0 for `GAP_CYCLES` cycles, then → PACK.
- WAIT_DONE:
  - First cycle with `sha_done`=1: latch `sha_hash` → REPORT.
  - Timeout counter reaching `DONE_TIMEOUT` → pulse `error`, → IDLE, `hash` unchanged.
- REPORT: `hash_valid`=1 for one cycle, → IDLE.
- `s_ready`=0 outside PACK. `req` outside IDLE is ignored. `sha_done` outside WAIT_DONE is ignored.
- Zero-length messages are unsupported, because `s_last` always accompanies a byte.
- A partial final word is left-aligned and zero-filled, e.g. "abc" → 0x61626300.
- `byte_count` wraps modulo 2^32. No saturation.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE;
  - `s_ready`, `sha_start`, `sha_valid`, `sha_last`, `hash_valid`, `busy`, `error` = 0;
  - `sha_data`, `hash`, `byte_count` = 0.
- `req` sampled at edge n → `sha_start` high during cycle n+1 → `s_ready` high from n+2.
- The byte accepted at edge m that completes a word → `sha_valid` high during cycle m+1.
- Minimum word period is 4 accept cycles + 1 SEND + `GAP_CYCLES`.
- `sha_done` sampled at edge d → `hash_valid` high during cycle d+1, `hash` already valid. `busy` falls at edge d+2.
- `rst_n` asserted mid-message: immediate return to reset values. The partial message is discarded, with no `sha_last` emitted.

## Structure
- Package `sha256_feeder_pkg`:
  - state enum;
  - `SHA_WORD_W`=32, `SHA_HASH_W`=256;
  - `BYTE_COUNT_W`=32.
- Sub-module `sha256_byte_packer`:
  - holds the byte index (0..3), word register, and zero-fill logic;
  - inputs: accept, byte, last, clear;
  - outputs: word, full, last_seen.
- The top level holds the FSM, gap/timeout counters, and the hash capture register.

## Test plan
- "abc" with `s_last` on 'c' and `GAP_CYCLES`=1:
  - one `sha_valid` with `sha_data`=0x61626300, `sha_last`=1;
  - `byte_count`=3;
  - against `sha256_processor`, `hash`=ba7816bf…f20015ad with one `hash_valid` pulse.
- 64 bytes 0x01..0x40:
  - 16 words, first 0x01020304, last 0x3D3E3F40;
  - `sha_last` only on word 16, with one idle cycle between each pair of pulses;
  - `byte_count`=0x40;
  - `hash`=cf5b16a7…7afee9d1.
- 56 bytes 0xAA with random `s_valid` bubbles:
  - 14 words of 0xAAAAAAAA;
  - `hash`=f08a78cb…ea6be342, identical to the no-bubble run.
- Stub that never raises `sha_done`, `DONE_TIMEOUT`=16:
  - `error` pulses once 16 cycles after the last word;
  - `hash_valid` stays 0 and the FSM returns to IDLE.
- `rst_n` low after 10 bytes of a 64-byte message:
  - all outputs return to 0 within the reset cycle;
  - a following "abc" message hashes correctly.
- `req` pulsed during PACK and `sha_done` pulsed during GAP:
  - both are ignored, with no extra `sha_start` and no early `hash_valid`.
